// File: rtl/eth_arp_receive_if.sv
// Receive-side byte stream into the ARP parser and the parsed result back out.
// The parser takes the slave modport. Whatever feeds bytes and consumes the result takes the master modport.
interface eth_arp_receive_if;
  logic        eth_rxdv;
  logic        rx_byte_en;
  logic [7:0]  rx_byte;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  modport master (
    output eth_rxdv, rx_byte_en, rx_byte,
    input  arp_rx_done, arp_rx_type, src_mac, src_ip
  );

  modport slave (
    input  eth_rxdv, rx_byte_en, rx_byte,
    output arp_rx_done, arp_rx_type, src_mac, src_ip
  );
endinterface

// File: rtl/eth_arp_receive.sv
// ARP frame detector: walks preamble, Ethernet header and ARP payload byte by byte.
// For a request or reply addressed to this board, it reports the sender MAC and IP.
module eth_arp_receive #(
  parameter logic [47:0] BOARD_MAC = 48'h2C_FE_07_19_68_33,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd110}
) (
  input logic              clk,
  input logic              rst_n,
  eth_arp_receive_if.slave arp
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREAMBLE = 3'd1;
  localparam logic [2:0] ETH_HEAD = 3'd2;
  localparam logic [2:0] ARP_DATA = 3'd3;
  localparam logic [2:0] RX_END   = 3'd4;

  logic [2:0]  state;
  logic [2:0]  pre_cnt;
  logic [4:0]  byte_cnt;
  logic        dmac_board;
  logic        dmac_bcast;
  logic        etype_hi_ok;
  logic        oper_reply;
  logic        vld_p0;
  logic [47:0] mac_tmp;
  logic [31:0] ip_tmp;

  function automatic logic [7:0] mac_byte(input logic [4:0] idx);
    case (idx)
      5'd0:    return BOARD_MAC[47:40];
      5'd1:    return BOARD_MAC[39:32];
      5'd2:    return BOARD_MAC[31:24];
      5'd3:    return BOARD_MAC[23:16];
      5'd4:    return BOARD_MAC[15:8];
      5'd5:    return BOARD_MAC[7:0];
      default: return 8'h00;
    endcase
  endfunction

  // Fixed ARP fields, oper, and target IP. Sender fields and target MAC pass unchecked.
  function automatic logic arp_byte_ok(input logic [4:0] idx, input logic [7:0] b);
    case (idx)
      5'd0, 5'd3, 5'd6: return b == 8'h00;
      5'd1:             return b == 8'h01;
      5'd2:             return b == 8'h08;
      5'd4:             return b == 8'h06;
      5'd5:             return b == 8'h04;
      5'd7:             return (b == 8'h01) || (b == 8'h02);
      5'd24:            return b == BOARD_IP[31:24];
      5'd25:            return b == BOARD_IP[23:16];
      5'd26:            return b == BOARD_IP[15:8];
      5'd27:            return b == BOARD_IP[7:0];
      default:          return 1'b1;
    endcase
  endfunction

  // Sender temporaries
  always_ff @(posedge clk) begin
    if (state == ARP_DATA && arp.rx_byte_en) begin
      if (byte_cnt >= 5'd8 && byte_cnt <= 5'd13)
        mac_tmp <= {mac_tmp[39:0], arp.rx_byte};
      if (byte_cnt >= 5'd14 && byte_cnt <= 5'd17)
        ip_tmp <= {ip_tmp[23:0], arp.rx_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      pre_cnt         <= 3'd0;
      byte_cnt        <= 5'd0;
      dmac_board      <= 1'b0;
      dmac_bcast      <= 1'b0;
      etype_hi_ok     <= 1'b0;
      oper_reply      <= 1'b0;
      vld_p0          <= 1'b0;
      arp.arp_rx_done <= 1'b0;
      arp.arp_rx_type <= 1'b0;
      arp.src_mac     <= 48'd0;
      arp.src_ip      <= 32'd0;
    end else begin
      // Result stage: commits one edge after the last target-IP byte, independent of eth_rxdv.
      vld_p0          <= 1'b0;
      arp.arp_rx_done <= vld_p0;
      if (vld_p0) begin
        arp.arp_rx_type <= oper_reply;
        arp.src_mac     <= mac_tmp;
        arp.src_ip      <= ip_tmp;
      end

      case (state)
        IDLE: begin
          if (arp.eth_rxdv && arp.rx_byte_en) begin
            byte_cnt <= 5'd0;
            if (arp.rx_byte == 8'h55) begin
              pre_cnt <= 3'd1;
              state   <= PREAMBLE;
            end else begin
              state <= RX_END;
            end
          end
        end

        PREAMBLE: begin
          if (!arp.eth_rxdv) begin
            state <= IDLE;
          end else if (arp.rx_byte_en) begin
            if (arp.rx_byte == 8'h55) begin
              if (pre_cnt != 3'd7) pre_cnt <= pre_cnt + 3'd1;
            end else if (arp.rx_byte == 8'hD5 && pre_cnt >= 3'd6) begin
              state      <= ETH_HEAD;
              byte_cnt   <= 5'd0;
              dmac_board <= 1'b1;
              dmac_bcast <= 1'b1;
            end else begin
              state <= RX_END;
            end
          end
        end

        ETH_HEAD: begin
          if (!arp.eth_rxdv) begin
            state <= IDLE;
          end else if (arp.rx_byte_en) begin
            byte_cnt <= byte_cnt + 5'd1;
            if (byte_cnt < 5'd6) begin
              if (arp.rx_byte != mac_byte(byte_cnt)) dmac_board <= 1'b0;
              if (arp.rx_byte != 8'hFF) dmac_bcast <= 1'b0;
            end
            if (byte_cnt == 5'd12) etype_hi_ok <= (arp.rx_byte == 8'h08);
            if (byte_cnt == 5'd13) begin
              byte_cnt <= 5'd0;
              state    <= ((dmac_board || dmac_bcast) && etype_hi_ok && arp.rx_byte == 8'h06)
                          ? ARP_DATA : RX_END;
            end
          end
        end

        ARP_DATA: begin
          // The final target-IP byte counts even when eth_rxdv drops on that same cycle.
          if (arp.rx_byte_en && (arp.eth_rxdv || byte_cnt == 5'd27)) begin
            if (!arp_byte_ok(byte_cnt, arp.rx_byte)) begin
              state <= RX_END;
            end else begin
              byte_cnt <= byte_cnt + 5'd1;
              if (byte_cnt == 5'd7) oper_reply <= (arp.rx_byte == 8'h02);
              if (byte_cnt == 5'd27) begin
                vld_p0 <= 1'b1;
                state  <= RX_END;
              end
            end
          end else if (!arp.eth_rxdv) begin
            state <= IDLE;
          end
        end

        RX_END: begin
          if (!arp.eth_rxdv) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_arp_receive.sv
// Bench for eth_arp_receive: directed and randomized ARP frames are checked against a frame-level reference model.
module tb_eth_arp_receive;
  localparam logic [47:0] BOARD_MAC = 48'h2C_FE_07_19_68_33;
  localparam logic [31:0] BOARD_IP  = 32'hC0A8016E;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  eth_arp_receive_if arp_bus();

  eth_arp_receive #(.BOARD_MAC(BOARD_MAC), .BOARD_IP(BOARD_IP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arp   (arp_bus)
  );

  always #4 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = -1;
  int cap_cyc = -1;
  logic [7:0]  frm[$];
  logic [47:0] exp_mac = '0;
  logic [31:0] exp_ip = '0;
  logic        exp_type = 1'b0;
  int          exp_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (arp_bus.arp_rx_done === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_cyc <= cyc;
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got still running want finished");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic dv, input logic en, input logic [7:0] b, input logic r);
    @(negedge clk);
    arp_bus.eth_rxdv   = dv;
    arp_bus.rx_byte_en = en;
    arp_bus.rx_byte    = b;
    rst_n              = r;
  endtask

  task automatic build(input int npre, input logic [47:0] dst, input logic [15:0] etype,
                       input logic [15:0] oper, input logic [47:0] smac,
                       input logic [31:0] sip, input logic [31:0] tip);
    frm.delete();
    repeat (npre) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int k = 0; k < 6; k++) frm.push_back(dst[47-8*k -: 8]);
    for (int k = 0; k < 6; k++) frm.push_back(8'(16 + k));
    frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h08);
    frm.push_back(8'h00); frm.push_back(8'h06); frm.push_back(8'h04);
    frm.push_back(oper[15:8]); frm.push_back(oper[7:0]);
    for (int k = 0; k < 6; k++) frm.push_back(smac[47-8*k -: 8]);
    for (int k = 0; k < 4; k++) frm.push_back(sip[31-8*k -: 8]);
    for (int k = 0; k < 6; k++) frm.push_back(8'h00);
    for (int k = 0; k < 4; k++) frm.push_back(tip[31-8*k -: 8]);
    for (int k = 0; k < 22; k++) frm.push_back(8'($urandom));
  endtask

  // gap_mode: 0 none, 1 one idle cycle per byte, 2 random 0..2 idle cycles
  task automatic send(input int n, input int gap_mode, input int rst_at,
                      input bit last_low, input int cap_idx);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int k = 0; k < g; k++) drive(1'b1, 1'b0, 8'($urandom), 1'b1);
      drive(!(last_low && i == n - 1), 1'b1, frm[i], i != rst_at);
      if (i == cap_idx) cap_cyc = cyc + 1;
    end
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  // Frame-level reference: decides acceptance from the byte list alone.
  task automatic model_frame(input int n, output bit ok, output logic [47:0] m,
                             output logic [31:0] ip, output logic t);
    int i, h, a;
    bit bc, bm;
    ok = 0; m = '0; ip = '0; t = 1'b0; i = 0;
    while (i < n && frm[i] == 8'h55) i++;
    if (i < 6 || i >= n || frm[i] != 8'hD5) return;
    h = i + 1;
    if (n < h + 42) return;
    bc = 1; bm = 1;
    for (int k = 0; k < 6; k++) begin
      if (frm[h+k] != 8'hFF) bc = 0;
      if (frm[h+k] != BOARD_MAC[47-8*k -: 8]) bm = 0;
    end
    if (!(bc || bm) || frm[h+12] != 8'h08 || frm[h+13] != 8'h06) return;
    a = h + 14;
    if ({frm[a], frm[a+1]} != 16'h0001 || {frm[a+2], frm[a+3]} != 16'h0800) return;
    if (frm[a+4] != 8'd6 || frm[a+5] != 8'd4) return;
    if ({frm[a+6], frm[a+7]} != 16'd1 && {frm[a+6], frm[a+7]} != 16'd2) return;
    if ({frm[a+24], frm[a+25], frm[a+26], frm[a+27]} != BOARD_IP) return;
    for (int k = 0; k < 6; k++) m = {m[39:0], frm[a+8+k]};
    for (int k = 0; k < 4; k++) ip = {ip[23:0], frm[a+14+k]};
    t = (frm[a+7] == 8'd2);
    ok = 1;
  endtask

  task automatic model_apply(input int n);
    bit ok; logic [47:0] m; logic [31:0] ip; logic t;
    model_frame(n, ok, m, ip, t);
    if (ok) begin
      exp_pulses++; exp_mac = m; exp_ip = ip; exp_type = t;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 8'h00, 1'b0);
    checks++; if (arp_bus.arp_rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", arp_bus.arp_rx_done); end
    checks++; if (arp_bus.arp_rx_type !== 1'b0) begin errors++; $display("FAIL reset_type: got %b want 0", arp_bus.arp_rx_type); end
    checks++; if (arp_bus.src_mac !== 48'd0) begin errors++; $display("FAIL reset_mac: got %h want 0", arp_bus.src_mac); end
    checks++; if (arp_bus.src_ip !== 32'd0) begin errors++; $display("FAIL reset_ip: got %h want 0", arp_bus.src_ip); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_bcast_request(input int gap_mode);
    build(7, BCAST, 16'h0806, 16'd1, 48'h002B67DD6C1C, 32'hC0A8010B, BOARD_IP);
    send(frm.size(), gap_mode, -1, 0, 49);
    model_apply(frm.size());
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL bcast_pulses(gap%0d): got %0d want %0d", gap_mode, pulse_cnt, exp_pulses); end
    checks++; if (arp_bus.arp_rx_type !== 1'b0) begin errors++; $display("FAIL bcast_type(gap%0d): got %b want 0", gap_mode, arp_bus.arp_rx_type); end
    checks++; if (arp_bus.src_mac !== 48'h002B67DD6C1C) begin errors++; $display("FAIL bcast_mac(gap%0d): got %h want 002b67dd6c1c", gap_mode, arp_bus.src_mac); end
    checks++; if (arp_bus.src_ip !== 32'hC0A8010B) begin errors++; $display("FAIL bcast_ip(gap%0d): got %h want c0a8010b", gap_mode, arp_bus.src_ip); end
    checks++; if (pulse_cyc !== cap_cyc + 1) begin errors++; $display("FAIL bcast_latency(gap%0d): got cycle %0d want %0d", gap_mode, pulse_cyc, cap_cyc + 1); end
  endtask

  task automatic test_unicast_reply();
    build(7, BOARD_MAC, 16'h0806, 16'd2, 48'h112233445566, 32'hC0A80114, BOARD_IP);
    send(frm.size(), 0, -1, 0, -1);
    model_apply(frm.size());
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL reply_pulses: got %0d want %0d", pulse_cnt, exp_pulses); end
    checks++; if (arp_bus.arp_rx_type !== 1'b1) begin errors++; $display("FAIL reply_type: got %b want 1", arp_bus.arp_rx_type); end
    checks++; if (arp_bus.src_mac !== 48'h112233445566) begin errors++; $display("FAIL reply_mac: got %h want 112233445566", arp_bus.src_mac); end
    checks++; if (arp_bus.src_ip !== 32'hC0A80114) begin errors++; $display("FAIL reply_ip: got %h want c0a80114", arp_bus.src_ip); end
  endtask

  task automatic test_bad_target();
    int p0;
    p0 = pulse_cnt;
    build(7, BCAST, 16'h0806, 16'd1, {$urandom, 16'($urandom)}, $urandom, 32'hC0A8016F);
    send(frm.size(), 0, -1, 0, -1);
    model_apply(frm.size());
    checks++; if (pulse_cnt !== p0) begin errors++; $display("FAIL badip_pulses: got %0d want %0d", pulse_cnt, p0); end
    checks++; if (arp_bus.src_mac !== 48'h112233445566) begin errors++; $display("FAIL badip_mac: got %h want 112233445566", arp_bus.src_mac); end
    checks++; if (arp_bus.src_ip !== 32'hC0A80114) begin errors++; $display("FAIL badip_ip: got %h want c0a80114", arp_bus.src_ip); end
    checks++; if (arp_bus.arp_rx_type !== 1'b1) begin errors++; $display("FAIL badip_type: got %b want 1", arp_bus.arp_rx_type); end
  endtask

  task automatic test_rejects();
    int p0;
    p0 = pulse_cnt;
    build(7, BCAST, 16'h0800, 16'd1, 48'hA1A2A3A4A5A6, 32'hC0A80199, BOARD_IP);
    send(frm.size(), 0, -1, 0, -1);
    model_apply(frm.size());
    build(5, BCAST, 16'h0806, 16'd1, 48'hB1B2B3B4B5B6, 32'hC0A80198, BOARD_IP);
    send(frm.size(), 0, -1, 0, -1);
    model_apply(frm.size());
    checks++; if (pulse_cnt !== p0) begin errors++; $display("FAIL reject_pulses: got %0d want %0d", pulse_cnt, p0); end
    build(6, BOARD_MAC, 16'h0806, 16'd1, {$urandom, 16'($urandom)}, $urandom, BOARD_IP);
    send(frm.size(), 0, -1, 0, -1);
    model_apply(frm.size());
    checks++; if (pulse_cnt !== p0 + 1) begin errors++; $display("FAIL after_reject_pulses: got %0d want %0d", pulse_cnt, p0 + 1); end
    checks++; if (arp_bus.src_mac !== exp_mac) begin errors++; $display("FAIL after_reject_mac: got %h want %h", arp_bus.src_mac, exp_mac); end
    checks++; if (arp_bus.src_ip !== exp_ip) begin errors++; $display("FAIL after_reject_ip: got %h want %h", arp_bus.src_ip, exp_ip); end
  endtask

  task automatic test_truncated();
    int p0;
    p0 = pulse_cnt;
    build(7, BCAST, 16'h0806, 16'd1, 48'hC1C2C3C4C5C6, 32'hC0A80177, BOARD_IP);
    send(8 + 14 + 10, 0, -1, 0, -1);
    model_apply(8 + 14 + 10);
    checks++; if (pulse_cnt !== p0) begin errors++; $display("FAIL trunc_pulses: got %0d want %0d", pulse_cnt, p0); end
    build(7, BCAST, 16'h0806, 16'd2, {$urandom, 16'($urandom)}, $urandom, BOARD_IP);
    send(frm.size(), 0, -1, 0, -1);
    model_apply(frm.size());
    checks++; if (pulse_cnt !== p0 + 1) begin errors++; $display("FAIL trunc_next_pulses: got %0d want %0d", pulse_cnt, p0 + 1); end
    checks++; if (arp_bus.src_mac !== exp_mac) begin errors++; $display("FAIL trunc_next_mac: got %h want %h", arp_bus.src_mac, exp_mac); end
    checks++; if (arp_bus.src_ip !== exp_ip) begin errors++; $display("FAIL trunc_next_ip: got %h want %h", arp_bus.src_ip, exp_ip); end
    checks++; if (arp_bus.arp_rx_type !== exp_type) begin errors++; $display("FAIL trunc_next_type: got %b want %b", arp_bus.arp_rx_type, exp_type); end
  endtask

  task automatic test_drop_on_last();
    build(7, BOARD_MAC, 16'h0806, 16'd1, {$urandom, 16'($urandom)}, $urandom, BOARD_IP);
    send(7 + 43, 0, -1, 1, -1);
    model_apply(7 + 43);
    checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL droplast_pulses: got %0d want %0d", pulse_cnt, exp_pulses); end
    checks++; if (arp_bus.src_mac !== exp_mac) begin errors++; $display("FAIL droplast_mac: got %h want %h", arp_bus.src_mac, exp_mac); end
    checks++; if (arp_bus.src_ip !== exp_ip) begin errors++; $display("FAIL droplast_ip: got %h want %h", arp_bus.src_ip, exp_ip); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  tail[$];
    logic [47:0] mac_a;
    int p0;
    p0 = pulse_cnt;
    build(7, BCAST, 16'h0806, 16'd1, 48'hD1D2D3D4D5D6, 32'hC0A80155, BOARD_IP);
    tail = frm;
    mac_a = {$urandom, 16'($urandom)};
    build(7, BCAST, 16'h0806, 16'd2, mac_a, 32'hC0A80156, BOARD_IP);
    foreach (tail[k]) frm.push_back(tail[k]);
    send(frm.size(), 0, -1, 0, -1);
    model_apply(frm.size());
    checks++; if (pulse_cnt !== p0 + 1) begin errors++; $display("FAIL b2b_pulses: got %0d want %0d", pulse_cnt, p0 + 1); end
    checks++; if (arp_bus.src_mac !== mac_a) begin errors++; $display("FAIL b2b_mac: got %h want %h", arp_bus.src_mac, mac_a); end
    checks++; if (arp_bus.src_ip !== 32'hC0A80156) begin errors++; $display("FAIL b2b_ip: got %h want c0a80156", arp_bus.src_ip); end
  endtask

  task automatic test_reset_midframe();
    int p0;
    p0 = pulse_cnt;
    build(7, BCAST, 16'h0806, 16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80133, BOARD_IP);
    send(frm.size(), 0, 8 + 5, 0, -1);
    exp_mac = '0; exp_ip = '0; exp_type = 1'b0;
    checks++; if (pulse_cnt !== p0) begin errors++; $display("FAIL midrst_pulses: got %0d want %0d", pulse_cnt, p0); end
    checks++; if (arp_bus.src_mac !== 48'd0) begin errors++; $display("FAIL midrst_mac: got %h want 0", arp_bus.src_mac); end
    checks++; if (arp_bus.src_ip !== 32'd0) begin errors++; $display("FAIL midrst_ip: got %h want 0", arp_bus.src_ip); end
    checks++; if (arp_bus.arp_rx_type !== 1'b0) begin errors++; $display("FAIL midrst_type: got %b want 0", arp_bus.arp_rx_type); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      logic [47:0] dst;
      int sel, n;
      sel = $urandom_range(0, 2);
      dst = (sel == 0) ? BCAST : (sel == 1) ? BOARD_MAC : {$urandom, 16'($urandom)};
      build($urandom_range(5, 8), dst,
            ($urandom_range(0, 5) == 0) ? 16'h0800 : 16'h0806,
            16'($urandom_range(0, 4) == 0 ? 3 : $urandom_range(1, 2)),
            {$urandom, 16'($urandom)}, $urandom,
            ($urandom_range(0, 3) == 0) ? (BOARD_IP ^ 32'd1) : BOARD_IP);
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, frm.size())) : frm.size();
      send(n, $urandom_range(0, 2), -1, (n != frm.size()) && $urandom_range(0, 1) == 1, -1);
      model_apply(n);
      checks++; if (pulse_cnt !== exp_pulses) begin errors++; $display("FAIL rand%0d_pulses: got %0d want %0d", it, pulse_cnt, exp_pulses); end
      checks++; if (arp_bus.src_mac !== exp_mac) begin errors++; $display("FAIL rand%0d_mac: got %h want %h", it, arp_bus.src_mac, exp_mac); end
      checks++; if (arp_bus.src_ip !== exp_ip) begin errors++; $display("FAIL rand%0d_ip: got %h want %h", it, arp_bus.src_ip, exp_ip); end
      checks++; if (arp_bus.arp_rx_type !== exp_type) begin errors++; $display("FAIL rand%0d_type: got %b want %b", it, arp_bus.arp_rx_type, exp_type); end
    end
  endtask

  initial begin
    arp_bus.eth_rxdv   = 1'b0;
    arp_bus.rx_byte_en = 1'b0;
    arp_bus.rx_byte    = 8'h00;
    test_reset();
    test_bcast_request(0);
    test_unicast_reply();
    test_bad_target();
    test_rejects();
    test_bcast_request(1);
    test_truncated();
    test_drop_on_last();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
